// File: rtl/onehot_pulse_decoder.sv
// -----------------------------------------------------------------------------
// onehot_pulse_decoder
//
// Purpose:
//   Accepts one W-bit index per valid/ready handshake. It drives the matching
//   bit of a one-hot N-bit output high for HOLD cycles, then strobes done in the
//   last driven cycle. The block sits downstream of the 4-input priority
//   encoder and re-creates timed per-channel strobes, for example LED or
//   actuator enables.
//
// Handshake:
//   A transfer happens on a rising edge where valid && ready.
//   - ready is combinational from state and reset only; it never looks at valid.
//   - code is captured only at the transfer edge.
//   - The source holds valid until it sees ready.
//   - Changes on code or valid while ready is low are ignored.
//
// Optional feature (macro DEC_GAP_EN):
//   When DEC_GAP_EN is defined, GAP_CYCLES idle cycles (y=0, busy=1, ready=0)
//   follow each pulse before the block returns to IDLE. This guarantees a low
//   gap between consecutive strobes, even on the same line. When the macro is
//   undefined, no GAP logic is built and GAP_CYCLES is ignored.
//
// Parameters:
//   W          code width (>= 1)
//   N          one-hot width, 2**W (derived; do not override)
//   HOLD       cycles the decoded line stays high (1..255)
//   GAP_CYCLES idle cycles after each pulse, DEC_GAP_EN only (1..255)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   code      in   [W-1:0] index to decode
//   valid     in   code is meaningful
//   ready     out  decoder can accept a code this cycle
//   y         out  [N-1:0] registered one-hot output, zero when not driving
//   busy      out  pulse (or gap) in progress
//   done      out  one-cycle strobe in the last driven cycle of a pulse
//   state_dbg out  [1:0] current FSM state (0=IDLE, 1=DRIVE, 2=GAP)
// -----------------------------------------------------------------------------
module onehot_pulse_decoder #(
  parameter int W          = 2,
  parameter int N          = 2**W,
  parameter int HOLD       = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] code,
  input  logic         valid,
  output logic         ready,
  output logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0]   HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_next;
  logic [7:0] hold_cnt;
  logic       transfer;
  logic       drive_last;

  assign transfer   = valid && ready;
  assign drive_last = (state == DRIVE) && (hold_cnt == 8'd0);

  // State register, hold counter and the registered one-hot output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      y        <= '0;
    end else begin
      state <= state_next;
      if (transfer) begin
        hold_cnt <= HOLD_LOAD;
        y        <= ONE << code;
      end else begin
        // The counter stops at zero; it is reloaded only on a transfer.
        if ((state == DRIVE) && (hold_cnt != 8'd0)) begin
          hold_cnt <= hold_cnt - 8'd1;
        end
        if (drive_last) begin
          y <= '0;
        end
      end
    end
  end

`ifdef DEC_GAP_EN
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  logic [7:0] gap_cnt;

  // The gap counter is loaded as DRIVE ends and counts GAP_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= 8'd0;
    end else if (drive_last) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == 8'd0) begin
`ifdef DEC_GAP_EN
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef DEC_GAP_EN
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready     = (state == IDLE) && !reset;
    busy      = (state != IDLE);
    done      = drive_last;
    state_dbg = state;
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_pulse_decoder
//
// Directed bench for onehot_pulse_decoder with W=2 and HOLD=4. Inputs change
// 1 ns after the rising edge, and outputs are sampled at that same point.
// When DEC_GAP_EN is defined, the bench runs with GAP_CYCLES=2 and expects the
// GAP cycles after each pulse.
// -----------------------------------------------------------------------------
module tb_onehot_pulse_decoder;

  localparam int W    = 2;
  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int GAPC = 2;

  logic         clk;
  logic         reset;
  logic [W-1:0] code;
  logic         valid;
  logic         ready;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int checks;
  int passes;
  int fails;

  onehot_pulse_decoder #(
    .W(W), .N(N), .HOLD(HOLD), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .code(code),
    .valid(valid),
    .ready(ready),
    .y(y),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] ey, input logic eb,
                         input logic ed, input logic er);
    chk({tag, ".y"},     32'(y),     32'(ey));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    chk({tag, ".done"},  32'(done),  32'(ed));
    chk({tag, ".ready"}, 32'(ready), 32'(er));
  endtask

  // Checks the HOLD driven cycles of a pulse. On entry the bench is already
  // in cycle T+1 after the transfer edge.
  task automatic pulse(input string tag, input logic [N-1:0] ey);
    for (int i = 1; i <= HOLD; i++) begin
      if (i > 1) tick();
      chk_out($sformatf("%s.c%0d", tag, i), ey, 1'b1, (i == HOLD), 1'b0);
    end
  endtask

  // Checks the cycles after the last driven cycle, ending in the IDLE cycle
  // where ready is high again.
  task automatic after_pulse(input string tag);
`ifdef DEC_GAP_EN
    for (int g = 1; g <= GAPC; g++) begin
      tick();
      chk_out($sformatf("%s.gap%0d", tag, g), '0, 1'b1, 1'b0, 1'b0);
    end
`endif
    tick();
    chk_out({tag, ".idle"}, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    reset  = 1'b1;
    valid  = 1'b1;
    code   = 2'd2;

    // Reset is held for 3 cycles while valid is high; nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rst%0d", i), '0, 1'b0, 1'b0, 1'b0);
    end
    chk("rst.state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(ready), 32'd1);

    // Single decode: code=2 is accepted at the next edge.
    tick();
    valid = 1'b0;
    pulse("single", 4'b0100);
    after_pulse("single");

    // All codes, with valid held and code stepped after each acceptance.
    valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      code = W'(k);
      tick();
      code = W'((k + 1) % 4);
      if (k == 3) valid = 1'b0;
      pulse($sformatf("all%0d", k), N'(1) << k);
      after_pulse($sformatf("all%0d", k));
    end

    // Ignore while busy: code changes during DRIVE have no effect.
    code  = 2'd3;
    valid = 1'b1;
    tick();
    code = 2'd0;
    pulse("busy3", 4'b1000);
    after_pulse("busy3");
    tick();
    valid = 1'b0;
    pulse("busy0", 4'b0001);
    after_pulse("busy0");

    // valid=0 is never decoded.
    code = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("novalid%0d", i), '0, 1'b0, 1'b0, 1'b1);
    end

    // Reset in DRIVE cycle 2 aborts the pulse without a done.
    code  = 2'd1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_out("abort.c1", 4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("abort.c2", 4'b0010, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("abort.rst", '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("abort.post%0d", i), '0, 1'b0, 1'b0, 1'b1);
    end

`ifdef DEC_GAP_EN
    // Back-to-back code=1 pulses are separated by 1 IDLE cycle plus the GAP cycles.
    code  = 2'd1;
    valid = 1'b1;
    tick();
    pulse("gapA", 4'b0010);
    after_pulse("gapA");
    tick();
    valid = 1'b0;
    pulse("gapB", 4'b0010);
    after_pulse("gapB");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Timeout watchdog
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
